// File: rtl/vga_rx_monitor_if.sv
// vga_rx_monitor_if: VGA receive stream, recovered timing outputs and probe port.
interface vga_rx_monitor_if;
  logic pix_ce;
  logic h_sync;
  logic v_sync;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;
  logic [9:0] probe_x;
  logic [9:0] probe_y;
  logic locked;
  logic de;
  logic [9:0] x;
  logic [9:0] y;
  logic [11:0] rgb;
  logic frame_start;
  logic [7:0] err_cnt;
  logic [11:0] probe_rgb;
  modport master (
    output pix_ce, h_sync, v_sync, red, green, blue, probe_x, probe_y,
    input locked, de, x, y, rgb, frame_start, err_cnt, probe_rgb
  );
  modport slave (
    input pix_ce, h_sync, v_sync, red, green, blue, probe_x, probe_y,
    output locked, de, x, y, rgb, frame_start, err_cnt, probe_rgb
  );
endinterface

// File: rtl/vga_rx_monitor.sv
// vga_rx_monitor: locks to an incoming VGA stream, recovers x/y/de and counts lock losses.
// Define VGA_RX_PROBE_EN to capture the colour seen at probe_x/probe_y.
module vga_rx_monitor #(
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int H_ACT       = 640,
  parameter int H_FP        = 16,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int V_ACT       = 480,
  parameter int V_FP        = 10,
  parameter int LOCK_FRAMES = 2
) (
  input logic clk,
  input logic rst,
  vga_rx_monitor_if.slave bus
);
  localparam logic [10:0] H_LAST = 11'(H_SYNC + H_BP + H_ACT + H_FP - 1);
  localparam logic [9:0]  V_LAST = 10'(V_SYNC + V_BP + V_ACT + V_FP - 1);
  localparam logic [10:0] H_LO   = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_HI   = 11'(H_SYNC + H_BP + H_ACT - 1);
  localparam logic [9:0]  V_LO   = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  V_HI   = 10'(V_SYNC + V_BP + V_ACT - 1);
  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;
  state_t r_state, w_state_nx;
  logic [7:0] r_good_cnt, w_good_cnt_nx;
  logic r_h_prev, r_v_prev, r_v_pend, r_lines_bad;
  logic [10:0] r_hcnt, w_hcnt_nx;
  logic [9:0] r_vcnt, w_vcnt_nx;
  logic r_locked, r_de, r_fs;
  logic [9:0] r_x, r_y, w_x, w_y;
  logic [11:0] r_rgb;
  logic [7:0] r_err_cnt;
  logic w_h_fall, w_v_fall, w_fs, w_line_good, w_frame_good, w_sat, w_err, w_de;
  assign w_h_fall     = r_h_prev & ~bus.h_sync;
  assign w_v_fall     = r_v_prev & ~bus.v_sync;
  assign w_fs         = w_h_fall & (r_v_pend | w_v_fall);
  assign w_line_good  = r_hcnt == H_LAST;
  assign w_frame_good = ~r_lines_bad & w_line_good & (r_vcnt == V_LAST);
  // flags the sample on which hcnt reaches (or sits at) its ceiling
  assign w_sat        = ~w_h_fall & (r_hcnt >= 11'd2046);
  assign w_hcnt_nx    = w_h_fall ? 11'd0 : r_hcnt + 11'(r_hcnt != 11'h7FF);
  assign w_vcnt_nx    = w_fs ? 10'd0 : w_h_fall ? r_vcnt + 10'(r_vcnt != 10'h3FF) : r_vcnt;
  assign w_x          = 10'(w_hcnt_nx - H_LO);
  assign w_y          = w_vcnt_nx - V_LO;
  assign w_de         = bus.pix_ce && w_state_nx == LOCKED && w_hcnt_nx >= H_LO && w_hcnt_nx <= H_HI
                        && w_vcnt_nx >= V_LO && w_vcnt_nx <= V_HI;
  always_comb begin
    w_state_nx    = r_state;
    w_good_cnt_nx = r_good_cnt;
    w_err         = 1'b0;
    if (bus.pix_ce) begin
      if (r_state == SEARCH) begin
        if (w_fs) begin
          w_state_nx    = TRACK;
          w_good_cnt_nx = 8'd0;
        end
      end else if (r_state == TRACK) begin
        if (w_sat) w_state_nx = SEARCH;
        else if (w_fs) begin
          w_good_cnt_nx = w_frame_good ? r_good_cnt + 8'd1 : 8'd0;
          if (w_frame_good && r_good_cnt + 8'd1 == 8'(LOCK_FRAMES)) w_state_nx = LOCKED;
        end
      end else if ((w_h_fall && !w_line_good) || (w_fs && !w_frame_good) || w_sat) begin
        w_state_nx = SEARCH;
        w_err      = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= SEARCH;
      r_good_cnt <= 8'd0;
    end else begin
      r_state    <= w_state_nx;
      r_good_cnt <= w_good_cnt_nx;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_h_prev    <= 1'b1;
      r_v_prev    <= 1'b1;
      r_v_pend    <= 1'b0;
      r_lines_bad <= 1'b0;
      r_hcnt      <= 11'd0;
      r_vcnt      <= 10'd0;
      r_locked    <= 1'b0;
      r_de        <= 1'b0;
      r_fs        <= 1'b0;
      r_x         <= 10'd0;
      r_y         <= 10'd0;
      r_rgb       <= 12'd0;
      r_err_cnt   <= 8'd0;
    end else begin
      r_locked <= w_state_nx == LOCKED;
      r_de     <= w_de;
      r_fs     <= bus.pix_ce & w_fs & (w_state_nx == LOCKED);
      if (bus.pix_ce) begin
        r_h_prev    <= bus.h_sync;
        r_v_prev    <= bus.v_sync;
        r_v_pend    <= ~w_fs & (r_v_pend | w_v_fall);
        r_lines_bad <= w_fs ? 1'b0 : r_lines_bad | (w_h_fall & ~w_line_good);
        r_hcnt      <= w_hcnt_nx;
        r_vcnt      <= w_vcnt_nx;
        if (w_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
      end
      if (w_de) begin
        r_x   <= w_x;
        r_y   <= w_y;
        r_rgb <= {bus.red, bus.green, bus.blue};
      end
    end
  end
  assign bus.locked      = r_locked;
  assign bus.de          = r_de;
  assign bus.x           = r_x;
  assign bus.y           = r_y;
  assign bus.rgb         = r_rgb;
  assign bus.frame_start = r_fs;
  assign bus.err_cnt     = r_err_cnt;
`ifdef VGA_RX_PROBE_EN
  logic [11:0] r_probe_rgb;
  always_ff @(posedge clk) begin
    if (!rst) r_probe_rgb <= 12'd0;
    else if (w_de && w_x == bus.probe_x && w_y == bus.probe_y) r_probe_rgb <= {bus.red, bus.green, bus.blue};
  end
  assign bus.probe_rgb = r_probe_rgb;
`else
  logic w_unused_probe;
  assign w_unused_probe = ^{bus.probe_x, bus.probe_y};
  assign bus.probe_rgb  = 12'd0;
`endif
endmodule

// File: tb/tb_vga_rx_monitor.sv
// tb_vga_rx_monitor: directed frames on a shrunken raster, de pixels checked against a scoreboard.
module tb_vga_rx_monitor;
  localparam int HS = 4, HB = 2, HA = 6, HF = 2, VS = 1, VB = 2, VA = 3, VF = 1;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;
`ifdef VGA_RX_PROBE_EN
  localparam logic [11:0] PROBE_EXP = 12'hF0F;
`else
  localparam logic [11:0] PROBE_EXP = 12'h000;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  vga_rx_monitor_if bus();
  vga_rx_monitor #(
    .H_SYNC(HS), .H_BP(HB), .H_ACT(HA), .H_FP(HF),
    .V_SYNC(VS), .V_BP(VB), .V_ACT(VA), .V_FP(VF), .LOCK_FRAMES(2)
  ) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  int exp_err = 0;
  int mode = 0;
  logic [31:0] sb[$];
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.de === 1'b1) begin
      check("de_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) check("pixel_xyrgb", {bus.x, bus.y, bus.rgb}, sb.pop_front());
    end
  end
  function automatic logic [11:0] pix(input int px, input int py);
    if (mode == 0) return 12'h5A3;
    return (px == HA - 1 && py == VA - 1) ? 12'hF0F : 12'h000;
  endfunction
  task automatic samp(input logic h, input logic v, input logic [11:0] c);
    @(negedge clk);
    bus.pix_ce = 1'b1;
    bus.h_sync = h;
    bus.v_sync = v;
    {bus.red, bus.green, bus.blue} = c;
    @(negedge clk);
    bus.pix_ce = 1'b0;
  endtask
  task automatic chk_zero(input string tag);
    check({tag, "_locked"}, bus.locked, 1'b0);
    check({tag, "_de"}, bus.de, 1'b0);
    check({tag, "_fs"}, bus.frame_start, 1'b0);
    check({tag, "_x"}, bus.x, 10'd0);
    check({tag, "_y"}, bus.y, 10'd0);
    check({tag, "_rgb"}, bus.rgb, 12'd0);
    check({tag, "_err"}, bus.err_cnt, 8'd0);
    check({tag, "_probe"}, bus.probe_rgb, 12'd0);
  endtask
  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask
  task automatic gen_frame(input int nl, input int short_ln, input logic lock_start, input int rst_ln);
    logic lk;
    lk = lock_start;
    for (int l = 0; l < nl; l++) begin
      if (l == rst_ln) begin
        pulse_rst();
        chk_zero("midrst");
        lk = 1'b0;
        exp_err = 0;
      end
      for (int p = 0; p < ((l == short_ln) ? HT - 1 : HT); p++) begin
        int px;
        int py;
        logic [11:0] c;
        px = p - HS - HB;
        py = l - VS - VB;
        c = pix(px, py);
        if (lk && px >= 0 && px < HA && py >= 0 && py < VA) sb.push_back({10'(px), 10'(py), c});
        samp(p >= HS, l >= VS, c);
        if (p == 0 && l == 0) begin
          check("fs_locked", bus.locked, lock_start);
          check("fs_pulse", bus.frame_start, lock_start);
        end else if (p == 1 && l == 0) check("fs_one_clk", bus.frame_start, 1'b0);
        else if (p == 0) check("line_locked", bus.locked, lk);
      end
      if (l == short_ln && lk) begin
        lk = 1'b0;
        exp_err++;
      end
    end
    check("err_cnt", bus.err_cnt, 32'(exp_err));
    check("sb_drained", sb.size(), 0);
  endtask
  initial begin
    bus.pix_ce = 1'b0;
    bus.h_sync = 1'b1;
    bus.v_sync = 1'b1;
    {bus.red, bus.green, bus.blue} = 12'h000;
    bus.probe_x = 10'd700;
    bus.probe_y = 10'(VA - 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    chk_zero("reset");
    gen_frame(VT, -1, 1'b0, -1);
    gen_frame(VT, -1, 1'b0, -1);
    gen_frame(VT, -1, 1'b1, -1);
    check("hold_x", bus.x, 10'(HA - 1));
    check("hold_y", bus.y, 10'(VA - 1));
    check("hold_rgb", bus.rgb, 12'h5A3);
    gen_frame(VT, 3, 1'b1, -1);
    gen_frame(VT, -1, 1'b0, -1);
    gen_frame(VT, -1, 1'b0, -1);
    gen_frame(VT, -1, 1'b1, -1);
    gen_frame(VT - 1, -1, 1'b1, -1);
    exp_err++;
    gen_frame(VT, -1, 1'b0, -1);
    gen_frame(VT, -1, 1'b0, -1);
    gen_frame(VT, -1, 1'b0, -1);
    gen_frame(VT, -1, 1'b1, -1);
    repeat (1000) samp(1'b1, 1'b1, 12'h5A3);
    check("stuck_still_locked", bus.locked, 1'b1);
    repeat (1100) samp(1'b1, 1'b1, 12'h5A3);
    exp_err++;
    check("stuck_lock_lost", bus.locked, 1'b0);
    check("stuck_err_cnt", bus.err_cnt, 32'(exp_err));
    check("stuck_sb_drained", sb.size(), 0);
    gen_frame(VT, -1, 1'b0, -1);
    gen_frame(VT, -1, 1'b0, -1);
    gen_frame(VT, -1, 1'b1, -1);
    gen_frame(VT, -1, 1'b1, 1);
    gen_frame(VT, -1, 1'b0, -1);
    gen_frame(VT, -1, 1'b0, -1);
    gen_frame(VT, -1, 1'b1, -1);
    check("probe_miss", bus.probe_rgb, 12'h000);
    bus.probe_x = 10'(HA - 1);
    bus.probe_y = 10'(VA - 1);
    mode = 1;
    gen_frame(VT, -1, 1'b1, -1);
    check("probe_hit", bus.probe_rgb, PROBE_EXP);
    check("last_rgb", bus.rgb, 12'hF0F);
    mode = 0;
    pulse_rst();
    chk_zero("rst2");
    gen_frame(VT - 1, -1, 1'b0, -1);
    gen_frame(VT, -1, 1'b0, -1);
    gen_frame(VT, -1, 1'b0, -1);
    gen_frame(VT, -1, 1'b1, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
